// File: rtl/adc_sample_ring_writer_if.sv
// -----------------------------------------------------------------------------
// adc_sample_ring_writer_if
//
// Write-side bus between the ADC ring writer and the sample RAM's s1 slave.
// The s1 slave has no waitrequest, so the bus is write-only with no backpressure.
//
// Signals:
//   mem_address    [ADDR_W-1:0]  RAM word address
//   mem_byteenable [3:0]         byte lanes of the write
//   mem_chipselect               RAM select (mirrors mem_write)
//   mem_write                    one-cycle write strobe
//   mem_writedata  [31:0]        packed sample word
//   mem_clken                    RAM clock enable (held high)
//
// Modports:
//   master - the ring writer (drives everything)
//   slave  - the RAM side (observes everything)
// -----------------------------------------------------------------------------
interface adc_sample_ring_writer_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;

    modport master (
        output mem_address,
        output mem_byteenable,
        output mem_chipselect,
        output mem_write,
        output mem_writedata,
        output mem_clken
    );

    modport slave (
        input mem_address,
        input mem_byteenable,
        input mem_chipselect,
        input mem_write,
        input mem_writedata,
        input mem_clken
    );
endinterface

// File: rtl/adc_sample_ring_writer.sv
// -----------------------------------------------------------------------------
// adc_sample_ring_writer
//
// Packs SAMPLE_W-bit ADC samples (zero-extended to 16 bits) in pairs into
// 32-bit words and writes them into a 2^ADDR_W-word RAM used as a circular
// buffer. The first sample of a pair is the low half-word. A pending single
// half-word can be pushed out with flush (byte lanes 1:0 only).
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   enable          accept samples while high
//   hold            CPU snapshot: no writes, incoming samples are dropped
//   clear           synchronous pulse emptying all buffer state (top priority)
//   flush           write a pending half-word
//   sample_valid    one-cycle qualifier for sample_data
//   sample_data     ADC result
//   mem             RAM write bus (adc_sample_ring_writer_if.master)
//   wr_ptr          next word address to be written
//   word_count      valid words in the RAM, saturating at 2^ADDR_W
//   wrapped         sticky, set when wr_ptr wraps from the last word to 0
//   overflow        sticky, set when any sample is dropped by hold
//   drop_count      dropped-sample counter
//
// Build option:
//   ADC_RING_DROP_CNT_EN  when defined, drop_count is a 16-bit saturating
//                         counter; otherwise drop_count is tied to zero.
// -----------------------------------------------------------------------------
module adc_sample_ring_writer #(
    parameter int SAMPLE_W = 12,
    parameter int ADDR_W   = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          hold,
    input  logic                          clear,
    input  logic                          flush,
    input  logic                          sample_valid,
    input  logic [SAMPLE_W-1:0]           sample_data,
    adc_sample_ring_writer_if.master      mem,
    output logic [ADDR_W-1:0]             wr_ptr,
    output logic [ADDR_W:0]               word_count,
    output logic                          wrapped,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } pack_state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [15:0] zext16(input logic [SAMPLE_W-1:0] s);
        return 16'(s);
    endfunction

    function automatic logic [ADDR_W:0] sat_inc_count(input logic [ADDR_W:0] c);
        return (c == DEPTH) ? c : c + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Input qualification
    // -------------------------------------------------------------------------
    logic accept;
    logic drop;

    // A sample coinciding with clear is discarded silently (neither accepted
    // nor counted as a drop).
    assign accept = sample_valid & enable & ~hold & ~clear;
    assign drop   = sample_valid & enable &  hold & ~clear;

    pack_state_t state_q;
    pack_state_t state_d;

    logic [15:0] lo_p0;
    logic        lo_load;
    logic        launch;
    logic [31:0] wr_data_d;
    logic [3:0]  wr_be_d;

    // -------------------------------------------------------------------------
    // Pack FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Pack FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_HALF;
                ST_HALF:  if (accept || (flush && !hold)) state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Pack FSM: outputs (write launch and half-word capture)
    // -------------------------------------------------------------------------
    always_comb begin
        launch    = 1'b0;
        lo_load   = 1'b0;
        wr_data_d = 32'h0;
        wr_be_d   = 4'h0;
        if (!clear) begin
            case (state_q)
                ST_EMPTY: begin
                    lo_load = accept;
                end
                ST_HALF: begin
                    // A completing sample wins over a simultaneous flush.
                    if (accept) begin
                        launch    = 1'b1;
                        wr_data_d = {zext16(sample_data), lo_p0};
                        wr_be_d   = 4'hF;
                    end else if (flush && !hold) begin
                        launch    = 1'b1;
                        wr_data_d = {16'h0, lo_p0};
                        wr_be_d   = 4'h3;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pending low half-word; only meaningful in ST_HALF, so it needs no reset.
    always_ff @(posedge clk) begin
        if (lo_load) begin
            lo_p0 <= zext16(sample_data);
        end
    end

    // -------------------------------------------------------------------------
    // Stage p1: registered RAM write strobes
    // -------------------------------------------------------------------------
    logic              vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [31:0]       wr_data_p1;
    logic [3:0]        wr_be_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= 32'h0;
            wr_be_p1   <= 4'h0;
        end else begin
            vld_p1 <= launch;
            if (launch) begin
                wr_addr_p1 <= wr_ptr;
                wr_data_p1 <= wr_data_d;
                wr_be_p1   <= wr_be_d;
            end
        end
    end

    assign mem.mem_write      = vld_p1;
    assign mem.mem_chipselect = vld_p1;
    assign mem.mem_address    = wr_addr_p1;
    assign mem.mem_writedata  = wr_data_p1;
    assign mem.mem_byteenable = wr_be_p1;
    assign mem.mem_clken      = 1'b1;

    // -------------------------------------------------------------------------
    // Ring bookkeeping, updated on the edge that launches the write so it is
    // already current while mem_write is high.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            word_count <= '0;
            wrapped    <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            word_count <= '0;
            wrapped    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (launch) begin
                wr_ptr     <= wr_ptr + 1'b1;
                word_count <= sat_inc_count(word_count);
                if (wr_ptr == LAST_PTR) begin
                    wrapped <= 1'b1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef ADC_RING_DROP_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'h1;
    endfunction

    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 16'h0;
        end else if (clear) begin
            drop_cnt_q <= 16'h0;
        end else if (drop) begin
            drop_cnt_q <= sat_inc16(drop_cnt_q);
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'h0;
`endif

endmodule

// File: doc/adc_sample_ring_writer.md
# adc_sample_ring_writer

Packs 12-bit ADC samples into 32-bit words and writes them into the 8-word on-chip sample RAM as a circular buffer. It sits directly upstream of the RAM's s1 slave, which has no waitrequest and always accepts a write. The Nios reads the RAM through s2 and uses `wr_ptr`, `word_count` and the status flags to locate the newest data. Sample ingest is paced by the ADC sequencer's `sample_valid` strobe.

## Interface
Parameters:
- `SAMPLE_W`, 12 — ADC sample width; each sample is zero-extended to 16 bits.
- `ADDR_W`, 3 — RAM address width; depth = 2^ADDR_W = 8 words.

Ports:
- `clk` in 1 — system clock; the block and the RAM share it.
- `reset` in 1 — asynchronous, active-high reset.
- `enable` in 1 — accept samples while high.
- `hold` in 1 — CPU snapshot request; while high, no RAM writes occur and incoming samples are dropped.
- `clear` in 1 — synchronous pulse that empties the buffer state.
- `flush` in 1 — pulse that writes a pending half-word.
- `sample_valid` in 1 — one-cycle strobe that qualifies `sample_data`.
- `sample_data` in SAMPLE_W — ADC result.
- `mem_address` out ADDR_W — RAM word address.
- `mem_byteenable` out 4 — RAM byte lanes.
- `mem_chipselect` out 1 — RAM select; equal to `mem_write`.
- `mem_write` out 1 — RAM write strobe.
- `mem_writedata` out 32 — packed word.
- `mem_clken` out 1 — RAM clock enable; constant 1.
- `wr_ptr` out ADDR_W — next word address to be written.
- `word_count` out ADDR_W+1 — number of valid words, saturating at 8.
- `wrapped` out 1 — sticky; set once `wr_ptr` has wrapped.
- `overflow` out 1 — sticky; set once any sample has been dropped.
- `drop_count` out 16 — dropped-sample counter (see Configuration).

## Operation
- Pack FSM has two states:
  - EMPTY: no sample held.
  - HALF: the low half-word is held in `lo_reg`.
- Sample acceptance: a sample is accepted when `sample_valid & enable & ~hold & ~clear`.
- EMPTY + accept:
  - Store `{ {16-SAMPLE_W{0}}, sample_data }` into `lo_reg`.
  - Go to HALF.
- HALF + accept:
  - Issue a write with data `{ext(sample_data), lo_reg}` and byteenable 4'b1111.
  - Go to EMPTY.
- Flush:
  - HALF + `flush` + no accept: write `{16'h0, lo_reg}` with byteenable 4'b0011, then go to EMPTY.
  - `flush` in EMPTY has no effect.
  - `flush` coinciding with an accept in HALF is ignored; the full word is written.
- Drop: `sample_valid & enable & hold` drops the sample.
  - Sets `overflow`.
  - Increments `drop_count`.
  - FSM state and `lo_reg` are retained.
- `sample_valid` while `enable`=0 is ignored silently; it is not counted as a drop.
- Each write, on completion:
  - `mem_address` = `wr_ptr`.
  - `wr_ptr` increments modulo 8; on the 7→0 transition, `wrapped` is set.
  - `word_count` increments, saturating at 8.
- Clear has priority over all other inputs. It zeroes `wr_ptr`, `word_count`, `wrapped`, `overflow` and `drop_count`, and returns the FSM to EMPTY. A sample arriving in the same cycle is discarded and is not counted as a drop.

## Timing
- Reset values: all outputs are 0 except `mem_clken`=1. `mem_write` deasserts asynchronously on `reset`. FSM resets to EMPTY.
- Write latency: the RAM strobes are registered. `mem_write`/`mem_chipselect` assert for exactly one cycle, on the cycle after the completing sample or flush is sampled. `mem_address`, `mem_writedata` and `mem_byteenable` are valid in that same cycle.
- Pointer and count: `wr_ptr` and `word_count` update on the same edge that launches the write strobe, so they reflect the write in the cycle `mem_write` is high.
- Throughput: the block must accept a sample every cycle with no loss. This gives at most one write per two cycles.
- Hold:
  - Rising `hold` takes effect on the same edge: no accept and no write is launched.
  - A write already registered in the cycle `hold` rises completes normally.
- Reset mid-write: the write is aborted and the RAM contents are not guaranteed for that word.

## Configuration
- `ADC_RING_DROP_CNT_EN` defined:
  - `drop_count` is a 16-bit counter saturating at 16'hFFFF.
  - It is cleared by `reset` or `clear`.
- `ADC_RING_DROP_CNT_EN` undefined:
  - `drop_count` is tied to 16'h0 and no counter logic is built.
  - `overflow` behaves identically in both builds.

## Test plan
- Pairing: samples 0x123, 0x456 on consecutive cycles → one write; `mem_address`=0, `mem_writedata`=0x0456_0123, `mem_byteenable`=4'hF, `wr_ptr`=1, `word_count`=1.
- Wrap: 18 back-to-back samples → 9 writes; the 9th goes to address 0, `wrapped`=1, `word_count`=8, `wr_ptr`=1.
- Flush: 3 samples then `flush` → 2nd write has `mem_writedata`=0x0000_0xxx (third sample) and byteenable 4'h3; `flush` in EMPTY → no write.
- Hold: HALF state, `hold`=1, 5 samples → no writes, `overflow`=1, `drop_count`=5. After release, the next sample completes a word with the retained `lo_reg`.
- Clear vs sample: `clear` and `sample_valid` in the same cycle → state EMPTY, all counters 0, `drop_count` unchanged at 0, no write.
- Async reset: assert `reset` in the cycle `mem_write`=1 → `mem_write` falls before the next edge and all outputs reach their reset values.
